alu_seq_ctrl: RTL and testbench

Byte-serial sequencer and result responder for the 8-bit ALU: the host writes an opcode byte, operand A and operand B over `ui_in`, each qualified by a strobe. The block runs one `alu_8bit` operation on full 8-bit operands and presents the registered result on `uo_out`, with a valid/ack handshake on `uio`. It removes the 3-bit/2-bit operand truncation of the combinational top and is the next tile-level top for the ALU project.

---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/alu_seq_if.sv | 12 +
 rtl/alu_8bit.sv | 26 ++
 rtl/alu_seq_ctrl_edge_sync.sv | 30 +++
 rtl/alu_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the byte-serial ALU sequencer tile.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_A  = 3'd1,
    GET_B  = 3'd2,
    EXEC   = 3'd3,
    RESULT = 3'd4
  } seq_state_t;

  localparam int STB_BIT   = 0;
  localparam int ACK_BIT   = 1;
  localparam int VALID_BIT = 4;
  localparam int BUSY_BIT  = 5;
  localparam int COUT_BIT  = 6;
  localparam int ERR_BIT   = 7;

  localparam int          SEL_W       = 3;
  localparam logic [7:0]  UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/alu_seq_if.sv
// Tile pin bundle: host drives ena/ui_in/uio_in, the sequencer drives the outputs.
interface alu_seq_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU: 8+8 -> 8-bit result with a separate carry/flag bit.
module alu_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [2:0] sel,
  output logic [7:0] Result,
  output logic       Cout
);
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    Result = 8'h00;
    Cout   = 1'b0;
    case (sel)
      3'b000: {Cout, Result} = {1'b0, A} + {1'b0, B};
      // Cout is the carry of A + ~B + 1, i.e. 1 when no borrow occurs.
      3'b001: {Cout, Result} = {1'b0, A} + {1'b0, ~B} + 9'd1;
      3'b010: Result = A & B;
      3'b011: Result = A | B;
      3'b100: Result = A ^ B;
      3'b101: {Cout, Result} = {A, 1'b0};
      3'b110: {Result, Cout} = {1'b0, A};
      3'b111: {Cout, Result} = {1'b0, A} + 9'd1;
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_seq_ctrl_edge_sync.sv
// Two-flop synchronizer with rising-edge pulse; a level already high out of reset is not a rise.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  logic s1, s2, s3;
  logic settled, armed;

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      settled <= 1'b0;
      armed   <= 1'b0;
    end else begin
      s1      <= din;
      s2      <= s1;
      s3      <= s2;
      settled <= 1'b1;
      // Arm only once a real post-reset sample of the pin has been seen low.
      if (settled && !s1) armed <= 1'b1;
    end
  end

  assign rise = s2 & ~s3 & armed;
endmodule

// File: rtl/alu_seq_ctrl.sv
// Byte-serial opcode/A/B sequencer around alu_8bit with a registered result and valid/ack handshake.
module alu_seq_ctrl
  import alu_seq_pkg::*;
(
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  logic stb_rise_raw, ack_rise_raw;
  logic stb_rise, ack_rise;
  logic unused_uio_bits;

  edge_sync u_stb_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.uio_in[STB_BIT]),
    .rise  (stb_rise_raw)
  );

  edge_sync u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.uio_in[ACK_BIT]),
    .rise  (ack_rise_raw)
  );

  // Synchronizers keep tracking while disabled; only the decoded edges are gated.
  assign stb_rise        = stb_rise_raw & bus.ena;
  assign ack_rise        = ack_rise_raw & bus.ena;
  assign unused_uio_bits = ^bus.uio_in[7:2];

  seq_state_t       state, state_next;
  logic             load_sel, load_a, load_b, do_exec;
  logic             set_err, clr_err, clr_valid;
  logic [SEL_W-1:0] sel;
  logic [7:0]       a_reg, b_reg, result_reg;
  logic             cout_reg, out_valid, err;
  logic [7:0]       alu_result;
  logic             alu_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_sel   = 1'b0;
    load_a     = 1'b0;
    load_b     = 1'b0;
    do_exec    = 1'b0;
    set_err    = 1'b0;
    clr_err    = 1'b0;
    clr_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (stb_rise) begin
          if (bus.ui_in[7:SEL_W] != '0) begin
            set_err = 1'b1;
          end else begin
            load_sel   = 1'b1;
            clr_err    = 1'b1;
            state_next = GET_A;
          end
        end
      end
      GET_A: begin
        if (ack_rise)      state_next = IDLE;
        else if (stb_rise) begin
          load_a     = 1'b1;
          state_next = GET_B;
        end
      end
      GET_B: begin
        if (ack_rise)      state_next = IDLE;
        else if (stb_rise) begin
          load_b     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        do_exec    = 1'b1;
        state_next = RESULT;
      end
      RESULT: begin
        if (stb_rise) set_err = 1'b1;
        if (ack_rise) begin
          clr_valid  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  alu_8bit u_alu (
    .A      (a_reg),
    .B      (b_reg),
    .sel    (sel),
    .Result (alu_result),
    .Cout   (alu_cout)
  );

  // NOTE: operand and result registers are reset too, so a reset fully clears the visible tile state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (load_sel) sel   <= bus.ui_in[SEL_W-1:0];
      if (load_a)   a_reg <= bus.ui_in;
      if (load_b)   b_reg <= bus.ui_in;
      if (do_exec) begin
        result_reg <= alu_result;
        cout_reg   <= alu_cout;
      end
      if (do_exec)        out_valid <= 1'b1;
      else if (clr_valid) out_valid <= 1'b0;
      if (set_err)        err <= 1'b1;
      else if (clr_err)   err <= 1'b0;
    end
  end

  always_comb begin
    bus.uio_out            = '0;
    bus.uio_out[VALID_BIT] = out_valid;
    bus.uio_out[BUSY_BIT]  = (state != IDLE);
    bus.uio_out[COUT_BIT]  = cout_reg;
    bus.uio_out[ERR_BIT]   = err;
  end

  assign bus.uo_out = result_reg;
  assign bus.uio_oe = UIO_OE_MASK;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scenario bench for alu_seq_ctrl against a transaction-level model of the byte protocol.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  alu_seq_if bus ();

  alu_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: bytes received in the current command (0..2), 3 = result pending ack.
  int         m_phase;
  logic [2:0] m_op;
  logic [7:0] m_a;
  logic [7:0] m_uo;
  logic       m_cout, m_valid, m_err;

  function automatic logic [8:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ai = a;
    int bi = b;
    int r  = 0;
    logic c = 1'b0;
    case (op)
      3'd0: begin r = (ai + bi) % 256; c = (ai + bi) > 255; end
      3'd1: begin r = (ai - bi + 256) % 256; c = (ai >= bi); end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: begin r = (ai * 2) % 256; c = (ai >= 128); end
      3'd6: begin r = ai / 2; c = (ai % 2) == 1; end
      default: begin r = (ai + 1) % 256; c = (ai == 255); end
    endcase
    return {c, 8'(r)};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_op = 0; m_a = 0; m_uo = 0; m_cout = 0; m_valid = 0; m_err = 0;
  endtask

  task automatic model_stb(input logic [7:0] v);
    logic [8:0] res;
    if (bus.ena !== 1'b1) return;
    case (m_phase)
      0: if (v > 8'd7) m_err = 1'b1;
         else begin m_op = v[2:0]; m_err = 1'b0; m_phase = 1; end
      1: begin m_a = v; m_phase = 2; end
      2: begin
        res = ref_alu(m_op, m_a, v);
        m_uo = res[7:0]; m_cout = res[8]; m_valid = 1'b1; m_phase = 3;
      end
      default: m_err = 1'b1;
    endcase
  endtask

  task automatic model_ack();
    if (bus.ena !== 1'b1) return;
    if (m_phase == 3) m_valid = 1'b0;
    m_phase = 0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    @(negedge clk);
    bus.ui_in = v;
    bus.uio_in[STB_BIT] = 1'b1;
    repeat (4) @(negedge clk);
    bus.uio_in[STB_BIT] = 1'b0;
    repeat (4) @(negedge clk);
    model_stb(v);
  endtask

  task automatic send_ack();
    @(negedge clk);
    bus.uio_in[ACK_BIT] = 1'b1;
    repeat (4) @(negedge clk);
    bus.uio_in[ACK_BIT] = 1'b0;
    repeat (4) @(negedge clk);
    model_ack();
  endtask

  task automatic test_reset();
    total++; if (bus.uo_out !== 8'h00) begin bad++; $display("FAIL reset_uo: got %h want 00", bus.uo_out); end
    total++; if (bus.uio_out !== 8'h00) begin bad++; $display("FAIL reset_uio_out: got %h want 00", bus.uio_out); end
    total++; if (bus.uio_oe !== 8'hF0) begin bad++; $display("FAIL reset_uio_oe: got %h want f0", bus.uio_oe); end
  endtask

  task automatic test_add();
    send_byte(8'h00);
    send_byte(8'hC8);
    @(negedge clk);
    bus.ui_in = 8'h50;
    bus.uio_in[STB_BIT] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.uio_out[VALID_BIT] !== 1'b0) begin bad++; $display("FAIL add_valid_early: got %b want 0", bus.uio_out[VALID_BIT]); end
    @(posedge clk);
    #1;
    total++; if (bus.uio_out[VALID_BIT] !== 1'b1) begin bad++; $display("FAIL add_valid: got %b want 1", bus.uio_out[VALID_BIT]); end
    total++; if (bus.uo_out !== 8'h18) begin bad++; $display("FAIL add_uo: got %h want 18", bus.uo_out); end
    total++; if (bus.uio_out[COUT_BIT] !== 1'b1) begin bad++; $display("FAIL add_cout: got %b want 1", bus.uio_out[COUT_BIT]); end
    repeat (3) @(negedge clk);
    bus.uio_in[STB_BIT] = 1'b0;
    repeat (4) @(negedge clk);
    model_stb(8'h50);
    @(negedge clk);
    bus.uio_in[ACK_BIT] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.uio_out[VALID_BIT] !== 1'b0) begin bad++; $display("FAIL add_ack_valid: got %b want 0", bus.uio_out[VALID_BIT]); end
    total++; if (bus.uio_out[BUSY_BIT] !== 1'b0) begin bad++; $display("FAIL add_ack_busy: got %b want 0", bus.uio_out[BUSY_BIT]); end
    total++; if (bus.uo_out !== 8'h18) begin bad++; $display("FAIL add_hold_uo: got %h want 18", bus.uo_out); end
    repeat (3) @(negedge clk);
    bus.uio_in[ACK_BIT] = 1'b0;
    repeat (4) @(negedge clk);
    model_ack();
  endtask

  task automatic test_reserved();
    send_byte(8'h28);
    total++; if (bus.uio_out[ERR_BIT] !== 1'b1) begin bad++; $display("FAIL rsvd_err: got %b want 1", bus.uio_out[ERR_BIT]); end
    total++; if (bus.uio_out[BUSY_BIT] !== 1'b0) begin bad++; $display("FAIL rsvd_busy: got %b want 0", bus.uio_out[BUSY_BIT]); end
    send_byte(8'h00);
    total++; if (bus.uio_out[ERR_BIT] !== 1'b0) begin bad++; $display("FAIL rsvd_clear_err: got %b want 0", bus.uio_out[ERR_BIT]); end
    total++; if (bus.uio_out[BUSY_BIT] !== 1'b1) begin bad++; $display("FAIL rsvd_get_a: got %b want 1", bus.uio_out[BUSY_BIT]); end
    send_ack();
  endtask

  task automatic test_abort();
    logic [7:0] prev;
    logic [2:0] op;
    logic [7:0] a, b;
    prev = m_uo;
    send_byte(8'h03);
    send_byte(8'h11);
    send_ack();
    total++; if (bus.uio_out[BUSY_BIT] !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", bus.uio_out[BUSY_BIT]); end
    total++; if (bus.uio_out[VALID_BIT] !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b want 0", bus.uio_out[VALID_BIT]); end
    total++; if (bus.uo_out !== prev) begin bad++; $display("FAIL abort_uo: got %h want %h", bus.uo_out, prev); end
    op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
    send_byte({5'b0, op}); send_byte(a); send_byte(b);
    total++; if (bus.uo_out !== m_uo) begin bad++; $display("FAIL abort_next_uo: got %h want %h", bus.uo_out, m_uo); end
    total++; if (bus.uio_out[COUT_BIT] !== m_cout) begin bad++; $display("FAIL abort_next_cout: got %b want %b", bus.uio_out[COUT_BIT], m_cout); end
    send_ack();
  endtask

  task automatic test_result_strobe();
    send_byte(8'h04); send_byte(8'h5A); send_byte(8'h0F);
    send_byte(8'hAA);
    total++; if (bus.uio_out[ERR_BIT] !== 1'b1) begin bad++; $display("FAIL rstb_err: got %b want 1", bus.uio_out[ERR_BIT]); end
    total++; if (bus.uo_out !== m_uo) begin bad++; $display("FAIL rstb_uo: got %h want %h", bus.uo_out, m_uo); end
    total++; if (bus.uio_out[VALID_BIT] !== 1'b1) begin bad++; $display("FAIL rstb_valid: got %b want 1", bus.uio_out[VALID_BIT]); end
    send_ack();
    total++; if (bus.uio_out[BUSY_BIT] !== 1'b0) begin bad++; $display("FAIL rstb_ack_busy: got %b want 0", bus.uio_out[BUSY_BIT]); end
  endtask

  task automatic test_ena();
    logic [7:0] prev;
    prev = m_uo;
    bus.ena = 1'b0;
    send_byte(8'h01); send_byte(8'h30); send_byte(8'h45);
    total++; if (bus.uio_out[BUSY_BIT] !== 1'b0) begin bad++; $display("FAIL ena_busy: got %b want 0", bus.uio_out[BUSY_BIT]); end
    total++; if (bus.uo_out !== prev) begin bad++; $display("FAIL ena_uo: got %h want %h", bus.uo_out, prev); end
    bus.ena = 1'b1;
    send_byte(8'h01); send_byte(8'h30); send_byte(8'h45);
    total++; if (bus.uo_out !== m_uo) begin bad++; $display("FAIL ena_on_uo: got %h want %h", bus.uo_out, m_uo); end
    total++; if (bus.uio_out[BUSY_BIT] !== 1'b1) begin bad++; $display("FAIL ena_on_busy: got %b want 1", bus.uio_out[BUSY_BIT]); end
    send_ack();
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [7:0] a, b;
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(8, 255)));
      send_byte({5'b0, op}); send_byte(a); send_byte(b);
      total++; if (bus.uo_out !== m_uo) begin bad++; $display("FAIL rand_uo[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, bus.uo_out, m_uo); end
      total++; if (bus.uio_out !== {m_err, m_cout, 1'b1, m_valid, 4'b0}) begin bad++; $display("FAIL rand_flags[%0d]: got %h want %h", i, bus.uio_out, {m_err, m_cout, 1'b1, m_valid, 4'b0}); end
      send_ack();
      total++; if (bus.uio_out !== {m_err, m_cout, 2'b00, 4'b0}) begin bad++; $display("FAIL rand_ack[%0d]: got %h want %h", i, bus.uio_out, {m_err, m_cout, 2'b00, 4'b0}); end
    end
  endtask

  task automatic test_async_reset();
    send_byte(8'h00); send_byte(8'hC8); send_byte(8'h50);
    send_ack();
    send_byte(8'h02); send_byte(8'h77);
    total++; if (bus.uio_out[BUSY_BIT] !== 1'b1) begin bad++; $display("FAIL arst_in_get_b: got %b want 1", bus.uio_out[BUSY_BIT]); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (bus.uo_out !== 8'h00) begin bad++; $display("FAIL arst_uo: got %h want 00", bus.uo_out); end
    total++; if (bus.uio_out !== 8'h00) begin bad++; $display("FAIL arst_uio_out: got %h want 00", bus.uio_out); end
    bus.ui_in = 8'h00;
    bus.uio_in[STB_BIT] = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    total++; if (bus.uio_out[BUSY_BIT] !== 1'b0) begin bad++; $display("FAIL arst_held_stb: got %b want 0", bus.uio_out[BUSY_BIT]); end
    bus.uio_in[STB_BIT] = 1'b0;
    repeat (4) @(negedge clk);
    bus.uio_in[STB_BIT] = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (bus.uio_out[BUSY_BIT] !== 1'b1) begin bad++; $display("FAIL arst_retoggle: got %b want 1", bus.uio_out[BUSY_BIT]); end
    bus.uio_in[STB_BIT] = 1'b0;
    repeat (4) @(negedge clk);
    model_stb(8'h00);
    send_ack();
    total++; if (bus.uio_out[BUSY_BIT] !== 1'b0) begin bad++; $display("FAIL arst_final_idle: got %b want 0", bus.uio_out[BUSY_BIT]); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_add();
    test_reserved();
    test_abort();
    test_result_strobe();
    test_ena();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
